// File: rtl/video_pkg.sv
// Shared VRAM geometry and arbiter defaults for the video subsystem.
package video_pkg;
   localparam int VRAM_AW      = 14;
   localparam int VRAM_DW      = 8;
   localparam int MAX_WAIT_DEF = 8;
   localparam int WAIT_W_DEF   = 4;
endpackage

// File: rtl/arb_wait_counter.sv
// Saturating, clearable wait counter with a >= threshold flag.
module arb_wait_counter #(
   parameter int W      = 4,
   parameter int THRESH = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   output logic [W-1:0] cnt,
   output logic         at_thresh
);
   localparam logic [W-1:0] THRESH_V = W'(THRESH);
   localparam logic [W-1:0] ONE      = W'(1);
   localparam logic [W-1:0] SAT      = '1;

   // Count pending cycles, holding at all-ones so the compare never wraps.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (cnt != SAT) begin
         cnt <= cnt + ONE;
      end
   end

   assign at_thresh = (cnt >= THRESH_V);
endmodule

// File: rtl/vram_arbiter.sv
// Shares VRAM port 1 between the Z80 bus interface (priority) and the
// block-copy engine, with a starvation guard and optional vblank-only BLT.
module vram_arbiter
   import video_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int WAIT_W   = WAIT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [13:0] cpu_addr,
   input  logic        cpu_wren,
   input  logic [7:0]  cpu_wrdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rddata,
   output logic        cpu_rdvalid,
   input  logic        blt_req,
   input  logic [13:0] blt_addr,
   input  logic        blt_wren,
   input  logic [7:0]  blt_wrdata,
   output logic        blt_ack,
   output logic [7:0]  blt_rddata,
   output logic        blt_rdvalid,
   input  logic        blt_vblank_only,
   input  logic        vblank,
   output logic [13:0] vram_addr,
   output logic [7:0]  vram_wrdata,
   output logic        vram_wren,
   input  logic [7:0]  vram_rddata
);
   logic              blt_eligible;
   logic              force_blt;
   logic              grant_blt;
   logic              grant_cpu;
   logic              wait_at_max;
   logic [WAIT_W-1:0] wait_cnt;

   // Read-issue tags: _p0 marks the address slot, _p1 the data-return slot.
   logic cpu_vld_p0, cpu_vld_p1;
   logic blt_vld_p0, blt_vld_p1;

   // Same-cycle grant: CPU wins unless BLT has waited MAX_WAIT cycles.
   always_comb begin
      blt_eligible = blt_req && (!blt_vblank_only || vblank);
      force_blt    = blt_eligible && wait_at_max;
      grant_blt    = blt_eligible && (force_blt || !cpu_req);
      grant_cpu    = cpu_req && !grant_blt;
   end

   assign cpu_ack = grant_cpu;
   assign blt_ack = grant_blt;

   arb_wait_counter #(
      .W      (WAIT_W),
      .THRESH (MAX_WAIT)
   ) u_wait (
      .clk       (clk),
      .reset     (reset),
      .clear     (!blt_eligible || grant_blt),
      .cnt       (wait_cnt),
      .at_thresh (wait_at_max)
   );

   // Issue stage: present the granted request to VRAM on the next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         vram_addr   <= '0;
         vram_wrdata <= '0;
         vram_wren   <= 1'b0;
      end else if (grant_blt) begin
         vram_addr   <= blt_addr;
         vram_wrdata <= blt_wrdata;
         vram_wren   <= blt_wren;
      end else if (grant_cpu) begin
         vram_addr   <= cpu_addr;
         vram_wrdata <= cpu_wrdata;
         vram_wren   <= cpu_wren;
      end else begin
         vram_wren   <= 1'b0;
      end
   end

   // Track which port owns each read so only its rdvalid pulses on return.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_vld_p0 <= 1'b0;
         cpu_vld_p1 <= 1'b0;
         blt_vld_p0 <= 1'b0;
         blt_vld_p1 <= 1'b0;
      end else begin
         cpu_vld_p0 <= grant_cpu && !cpu_wren;
         cpu_vld_p1 <= cpu_vld_p0;
         blt_vld_p0 <= grant_blt && !blt_wren;
         blt_vld_p1 <= blt_vld_p0;
      end
   end

   assign cpu_rdvalid = cpu_vld_p1;
   assign blt_rdvalid = blt_vld_p1;
   assign cpu_rddata  = vram_rddata;
   assign blt_rddata  = vram_rddata;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a default instance backed by a VRAM model
// and a MAX_WAIT=15 instance sharing its inputs for the saturation case.
module tb_vram_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_wren, blt_req, blt_wren;
   logic [13:0] cpu_addr, blt_addr;
   logic [7:0]  cpu_wrdata, blt_wrdata;
   logic        blt_vblank_only, vblank;

   logic        cpu_ack, cpu_rdvalid, blt_ack, blt_rdvalid, vram_wren;
   logic [7:0]  cpu_rddata, blt_rddata, vram_wrdata, vram_rddata;
   logic [13:0] vram_addr;

   logic        s_cpu_ack, s_cpu_rdvalid, s_blt_ack, s_blt_rdvalid, s_vram_wren;
   logic [7:0]  s_cpu_rddata, s_blt_rddata, s_vram_wrdata;
   logic [7:0]  s_vram_rddata;
   logic [13:0] s_vram_addr;

   logic [7:0]  mem [0:16383];

   int n_cmp = 0;
   int n_bad = 0;

   assign s_vram_rddata = 8'h00;

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
      .cpu_wrdata(cpu_wrdata), .cpu_ack(cpu_ack), .cpu_rddata(cpu_rddata),
      .cpu_rdvalid(cpu_rdvalid),
      .blt_req(blt_req), .blt_addr(blt_addr), .blt_wren(blt_wren),
      .blt_wrdata(blt_wrdata), .blt_ack(blt_ack), .blt_rddata(blt_rddata),
      .blt_rdvalid(blt_rdvalid),
      .blt_vblank_only(blt_vblank_only), .vblank(vblank),
      .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
      .vram_rddata(vram_rddata)
   );

   vram_arbiter #(.MAX_WAIT(15), .WAIT_W(4)) dut15 (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wren(cpu_wren),
      .cpu_wrdata(cpu_wrdata), .cpu_ack(s_cpu_ack), .cpu_rddata(s_cpu_rddata),
      .cpu_rdvalid(s_cpu_rdvalid),
      .blt_req(blt_req), .blt_addr(blt_addr), .blt_wren(blt_wren),
      .blt_wrdata(blt_wrdata), .blt_ack(s_blt_ack), .blt_rddata(s_blt_rddata),
      .blt_rdvalid(s_blt_rdvalid),
      .blt_vblank_only(blt_vblank_only), .vblank(vblank),
      .vram_addr(s_vram_addr), .vram_wrdata(s_vram_wrdata), .vram_wren(s_vram_wren),
      .vram_rddata(s_vram_rddata)
   );

   // VRAM port model: registered read, write takes effect at the same edge.
   always @(posedge clk) begin
      if (vram_wren) mem[vram_addr] <= vram_wrdata;
      vram_rddata <= mem[vram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // CPU write followed immediately by a read of the same address.
   task automatic cpu_wr_rd(input logic [13:0] a, input logic [7:0] d);
      cpu_req = 1'b1; cpu_addr = a; cpu_wren = 1'b1; cpu_wrdata = d;
      #1;
      chk("wr_cpu_ack", 32'(cpu_ack), 1);
      chk("wr_blt_ack", 32'(blt_ack), 0);
      tick();
      chk("wr_vram_wren", 32'(vram_wren), 1);
      chk("wr_vram_addr", 32'(vram_addr), 32'(a));
      chk("wr_vram_wrdata", 32'(vram_wrdata), 32'(d));
      cpu_wren = 1'b0;
      #1;
      chk("rd_cpu_ack", 32'(cpu_ack), 1);
      tick();
      chk("rd_vram_wren", 32'(vram_wren), 0);
      chk("rd_vram_addr", 32'(vram_addr), 32'(a));
      chk("rd_rdvalid_early", 32'(cpu_rdvalid), 0);
      cpu_req = 1'b0;
      tick();
      chk("rd_cpu_rdvalid", 32'(cpu_rdvalid), 1);
      chk("rd_cpu_rddata", 32'(cpu_rddata), 32'(d));
      chk("rd_blt_rdvalid", 32'(blt_rdvalid), 0);
      tick();
      chk("rd_rdvalid_end", 32'(cpu_rdvalid), 0);
   endtask

   initial begin
      reset = 1'b1;
      cpu_req = 1'b0; cpu_addr = '0; cpu_wren = 1'b0; cpu_wrdata = '0;
      blt_req = 1'b0; blt_addr = '0; blt_wren = 1'b0; blt_wrdata = '0;
      blt_vblank_only = 1'b0; vblank = 1'b0;
      tick();
      tick();
      chk("rst_vram_addr", 32'(vram_addr), 0);
      chk("rst_vram_wrdata", 32'(vram_wrdata), 0);
      chk("rst_vram_wren", 32'(vram_wren), 0);
      chk("rst_cpu_rdvalid", 32'(cpu_rdvalid), 0);
      chk("rst_blt_rdvalid", 32'(blt_rdvalid), 0);
      chk("rst_wait_cnt", 32'(dut.wait_cnt), 0);
      reset = 1'b0;
      tick();

      // CPU-only traffic, including read-after-write on consecutive slots
      cpu_wr_rd(14'h1234, 8'h5A);
      cpu_wr_rd(14'h0010, 8'hAA);

      // vblank-only: BLT held off while vblank=0, counter stays clear
      blt_vblank_only = 1'b1; vblank = 1'b0;
      blt_req = 1'b1; blt_addr = 14'h0010; blt_wren = 1'b0;
      #1;
      chk("vbo_blt_ack_0", 32'(blt_ack), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("vbo_blt_ack_held", 32'(blt_ack), 0);
         chk("vbo_wait_cnt", 32'(dut.wait_cnt), 0);
      end
      vblank = 1'b1;
      #1;
      chk("vbo_blt_ack_rise", 32'(blt_ack), 1);
      chk("vbo_cpu_ack", 32'(cpu_ack), 0);
      tick();
      chk("vbo_vram_addr", 32'(vram_addr), 32'h0010);
      chk("vbo_vram_wren", 32'(vram_wren), 0);
      blt_req = 1'b0;
      tick();
      chk("vbo_blt_rdvalid", 32'(blt_rdvalid), 1);
      chk("vbo_blt_rddata", 32'(blt_rddata), 32'hAA);
      chk("vbo_cpu_rdvalid", 32'(cpu_rdvalid), 0);

      // vblank falls while BLT waits behind the CPU: counter clears
      cpu_req = 1'b1; cpu_addr = 14'h2000; cpu_wren = 1'b1; cpu_wrdata = 8'h11;
      blt_req = 1'b1; blt_addr = 14'h3000; blt_wren = 1'b1; blt_wrdata = 8'h22;
      for (int i = 0; i < 3; i++) tick();
      chk("vbf_wait_cnt_3", 32'(dut.wait_cnt), 3);
      vblank = 1'b0;
      #1;
      chk("vbf_blt_ack", 32'(blt_ack), 0);
      chk("vbf_cpu_ack", 32'(cpu_ack), 1);
      tick();
      chk("vbf_wait_cnt_0", 32'(dut.wait_cnt), 0);

      // Contention: BLT forced every MAX_WAIT+1 cycles, 15-threshold copy alongside
      blt_vblank_only = 1'b0;
      blt_req = 1'b0; cpu_req = 1'b0;
      tick();
      cpu_req = 1'b1; blt_req = 1'b1;
      for (int i = 0; i < 32; i++) begin
         #1;
         chk("con_blt_ack", 32'(blt_ack), 32'((i % 9) == 8));
         chk("con_cpu_ack", 32'(cpu_ack), 32'((i % 9) != 8));
         chk("con_wait_cnt", 32'(dut.wait_cnt), 32'(i % 9));
         chk("sat_blt_ack", 32'(s_blt_ack), 32'((i % 16) == 15));
         chk("sat_wait_cnt", 32'(dut15.wait_cnt), 32'(i % 16));
         tick();
      end

      // Reset lands while a BLT read is in flight: no rdvalid may escape
      cpu_req = 1'b0;
      blt_req = 1'b1; blt_addr = 14'h1234; blt_wren = 1'b0;
      #1;
      chk("rmr_blt_ack", 32'(blt_ack), 1);
      tick();
      reset = 1'b1; blt_req = 1'b0;
      tick();
      chk("rmr_blt_rdvalid", 32'(blt_rdvalid), 0);
      chk("rmr_cpu_rdvalid", 32'(cpu_rdvalid), 0);
      chk("rmr_vram_addr", 32'(vram_addr), 0);
      chk("rmr_vram_wrdata", 32'(vram_wrdata), 0);
      chk("rmr_vram_wren", 32'(vram_wren), 0);
      reset = 1'b0;
      tick();
      chk("rmr_blt_rdvalid_after", 32'(blt_rdvalid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
